// File: rtl/countdown_16.sv
// Loadable down-counter sequencer: start captures N, counts down on enabled
// cycles, and emits a one-cycle done pulse after the terminal-count cycle.
module countdown_16 #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             count_is_zero;

    assign count_is_zero = (count_reg == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        count_reg <= load_value;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here: no reload mid-run
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (enable && !count_is_zero) begin
                        count_reg <= count_reg - WIDTH'(1);
                        busy_reg  <= 1'b1;
                    end else if (enable) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        busy_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // abort has no effect here; the pulse is already out
                    if (start) begin
                        state_reg <= RUN;
                        count_reg <= load_value;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign tick  = (state_reg == RUN) && enable && !count_is_zero;

endmodule
